ifu_test_sequencer: RTL

//  Parametrised on-FPGA test sequencer for the instruction fetch unit. It drives fetch_next/stall, counts accepted

---
 rtl/ifu_test_sequencer_if.sv | 41 ++++
 rtl/ifu_test_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_test_sequencer_if.sv
// Signal bundle between the IFU test sequencer, its controls, the ground-truth table and the IFU.
// The master modport is the sequencer's view; slave is the environment's view.
interface ifu_test_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_num_instr;
  logic             cfg_stall_en;
  logic [3:0]       cfg_stall_thresh;
  logic             instruction_valid;
  logic [31:0]      instruction_pc;
  logic             gt_valid;
  logic             gt_taken;
  logic [31:0]      gt_target;
  logic             fetch_next;
  logic             stall;
  logic             branch_resolved;
  logic             branch_taken;
  logic [31:0]      branch_pc;
  logic [31:0]      branch_target;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] instr_count;
  logic [31:0]      cycle_count;

  modport master (
    input  start, abort, cfg_num_instr, cfg_stall_en, cfg_stall_thresh,
           instruction_valid, instruction_pc, gt_valid, gt_taken, gt_target,
    output fetch_next, stall, branch_resolved, branch_taken, branch_pc, branch_target,
           busy, done, timeout_err, instr_count, cycle_count
  );

  modport slave (
    output start, abort, cfg_num_instr, cfg_stall_en, cfg_stall_thresh,
           instruction_valid, instruction_pc, gt_valid, gt_taken, gt_target,
    input  fetch_next, stall, branch_resolved, branch_taken, branch_pc, branch_target,
           busy, done, timeout_err, instr_count, cycle_count
  );
endinterface

// File: rtl/ifu_test_sequencer.sv
// Test sequencer for the IFU: consumes instructions, injects LFSR stalls, replays ground-truth
// branch outcomes after RESOLVE_LAT cycles, and guards progress with a watchdog.
module ifu_test_sequencer #(
  parameter int          CNT_W          = 16,
  parameter int          RESOLVE_LAT    = 3,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ifu_test_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  state_e           state_r;
  logic             start_q_r;
  logic [CNT_W-1:0] num_r;
  logic             stall_en_r;
  logic [3:0]       thresh_r;
  logic [15:0]      lfsr_r;
  logic [WD_W-1:0]  wd_r;
  logic             fetch_next_r;
  logic             stall_r;
  logic             busy_r;
  logic             done_r;
  logic             timeout_err_r;
  logic [CNT_W-1:0] instr_count_r;
  logic [31:0]      cycle_count_r;

  logic             dl_v_r      [RESOLVE_LAT];
  logic [31:0]      dl_pc_r     [RESOLVE_LAT];
  logic             dl_taken_r  [RESOLVE_LAT];
  logic [31:0]      dl_target_r [RESOLVE_LAT];

  logic             start_edge_s;
  logic             accept_s;
  logic             timeout_s;
  logic             flush_s;
  logic             load_v_s;
  logic             pending_s;
  logic [15:0]      lfsr_nxt_s;
  logic             stall_nxt_s;
  logic [CNT_W-1:0] instr_inc_s;
  logic [31:0]      cyc_inc_s;

  assign start_edge_s = bus.start & ~start_q_r;
  assign accept_s     = bus.instruction_valid & fetch_next_r & ~stall_r;
  assign timeout_s    = (state_r == RUN) & ~accept_s & (wd_r == WD_LAST);
  assign flush_s      = bus.abort | timeout_s;
  assign load_v_s     = accept_s & bus.gt_valid & ~flush_s;
  assign lfsr_nxt_s   = lfsr_step(lfsr_r);
  assign stall_nxt_s  = stall_en_r & (lfsr_nxt_s[3:0] < thresh_r);
  assign instr_inc_s  = instr_count_r + CNT_W'(1);
  assign cyc_inc_s    = (cycle_count_r == 32'hFFFF_FFFF) ? cycle_count_r : cycle_count_r + 32'd1;

  // Any branch still travelling toward the output stage keeps DRAIN alive.
  always_comb begin
    pending_s = 1'b0;
    for (int i = 0; i < RESOLVE_LAT - 1; i++) begin
      pending_s = pending_s | dl_v_r[i];
    end
  end

  // Run-control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      start_q_r     <= 1'b0;
      num_r         <= '0;
      stall_en_r    <= 1'b0;
      thresh_r      <= 4'd0;
      lfsr_r        <= LFSR_SEED;
      wd_r          <= '0;
      fetch_next_r  <= 1'b0;
      stall_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      instr_count_r <= '0;
      cycle_count_r <= 32'd0;
    end else begin
      start_q_r <= bus.start;
      if (bus.abort) begin
        state_r       <= IDLE;
        fetch_next_r  <= 1'b0;
        stall_r       <= 1'b0;
        busy_r        <= 1'b0;
        done_r        <= 1'b0;
        timeout_err_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE, DONE, ERROR: begin
            if (start_edge_s) begin
              state_r       <= RUN;
              num_r         <= bus.cfg_num_instr;
              stall_en_r    <= bus.cfg_stall_en;
              thresh_r      <= bus.cfg_stall_thresh;
              lfsr_r        <= LFSR_SEED;
              wd_r          <= '0;
              instr_count_r <= '0;
              cycle_count_r <= 32'd0;
              fetch_next_r  <= (bus.cfg_num_instr != '0);
              stall_r       <= bus.cfg_stall_en & (LFSR_SEED[3:0] < bus.cfg_stall_thresh);
              busy_r        <= 1'b1;
              done_r        <= 1'b0;
              timeout_err_r <= 1'b0;
            end
          end
          RUN: begin
            cycle_count_r <= cyc_inc_s;
            lfsr_r        <= lfsr_nxt_s;
            if (num_r == '0) begin
              state_r      <= DRAIN;
              fetch_next_r <= 1'b0;
              stall_r      <= 1'b0;
            end else if (accept_s) begin
              instr_count_r <= instr_inc_s;
              wd_r          <= '0;
              if (instr_inc_s == num_r) begin
                state_r      <= DRAIN;
                fetch_next_r <= 1'b0;
                stall_r      <= 1'b0;
              end else begin
                stall_r <= stall_nxt_s;
              end
            end else if (timeout_s) begin
              state_r       <= ERROR;
              fetch_next_r  <= 1'b0;
              stall_r       <= 1'b0;
              busy_r        <= 1'b0;
              timeout_err_r <= 1'b1;
            end else begin
              wd_r    <= wd_r + WD_W'(1);
              stall_r <= stall_nxt_s;
            end
          end
          DRAIN: begin
            cycle_count_r <= cyc_inc_s;
            if (!pending_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
          default: begin
            state_r       <= IDLE;
            fetch_next_r  <= 1'b0;
            stall_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Resolve delay line; the last stage doubles as the branch_* output register and holds on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESOLVE_LAT; i++) begin
        dl_v_r[i]      <= 1'b0;
        dl_pc_r[i]     <= 32'd0;
        dl_taken_r[i]  <= 1'b0;
        dl_target_r[i] <= 32'd0;
      end
    end else begin
      dl_v_r[0] <= load_v_s;
      if (load_v_s) begin
        dl_pc_r[0]     <= bus.instruction_pc;
        dl_taken_r[0]  <= bus.gt_taken;
        dl_target_r[0] <= bus.gt_target;
      end
      for (int i = 1; i < RESOLVE_LAT; i++) begin
        dl_v_r[i] <= dl_v_r[i-1] & ~flush_s;
        if (dl_v_r[i-1] & ~flush_s) begin
          dl_pc_r[i]     <= dl_pc_r[i-1];
          dl_taken_r[i]  <= dl_taken_r[i-1];
          dl_target_r[i] <= dl_target_r[i-1];
        end
      end
    end
  end

  assign bus.fetch_next      = fetch_next_r;
  assign bus.stall           = stall_r;
  assign bus.branch_resolved = dl_v_r[RESOLVE_LAT-1];
  assign bus.branch_taken    = dl_taken_r[RESOLVE_LAT-1];
  assign bus.branch_pc       = dl_pc_r[RESOLVE_LAT-1];
  assign bus.branch_target   = dl_target_r[RESOLVE_LAT-1];
  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.timeout_err     = timeout_err_r;
  assign bus.instr_count     = instr_count_r;
  assign bus.cycle_count     = cycle_count_r;

endmodule
